// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the product -> BCD display path.
//   state_t    : converter FSM states (IDLE, CONVERT, DONE)
//   BCD_WIDTH  : binary input width (8)
//   BCD_DIGITS : number of packed BCD output digits (3)
//   BCD_CNT_W  : width of the iteration counter, clog2(BCD_WIDTH+1)
//   seg7_lut   : BCD nibble -> 7-segment pattern, ordered gfedcba, active-low.
//                Used only when PRODUCT_BCD_SEG7_EN is defined.
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_WIDTH  = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_CNT_W  = $clog2(BCD_WIDTH + 1);

    // Non-decimal nibbles cannot occur on the BCD path; they map to blank.
    function automatic logic [6:0] seg7_lut(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// One double-dabble correction cell: adds 3 to a BCD nibble when it is >= 5,
// so that the following left shift carries correctly into the next digit.
// The sum stays within 4 bits because the input of a valid iteration is <= 9.
//   din  : BCD nibble before correction
//   dout : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/product_bcd_converter.sv
// -----------------------------------------------------------------------------
// product_bcd_converter
// Sequential double-dabble converter for the 8-bit multiplier product. One
// binary bit is processed per clock; the result is three packed BCD digits.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : product_in is valid
//   in_ready    : converter can accept a product (high only in IDLE)
//   product_in  : unsigned product
//   out_valid   : bcd_out holds a completed conversion (high only in DONE)
//   out_ready   : downstream consumes the result
//   bcd_out     : [11:8] hundreds, [7:4] tens, [3:0] ones
//   busy        : high while converting
//   seg_hund/seg_tens/seg_ones (only with PRODUCT_BCD_SEG7_EN defined):
//                 registered 7-segment patterns, gfedcba, active-low
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid outside IDLE and out_ready outside DONE are ignored;
// nothing is queued. bcd_out only changes when a conversion completes.
//
// Timing: accept at edge 0, eight iterations on edges 1..8, out_valid visible
// after edge 8, earliest release on edge 9, next accept no earlier than edge 10.
// -----------------------------------------------------------------------------
module product_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = BCD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      product_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
`ifdef PRODUCT_BCD_SEG7_EN
    ,
    output logic [6:0]            seg_hund,
    output logic [6:0]            seg_tens,
    output logic [6:0]            seg_ones
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;

    state_t                 state;
    state_t                 state_nxt;

    // Shift register: BCD field in the top BCD_W bits, binary in the low WIDTH.
    logic [SR_W-1:0]        sr;
    logic [SR_W-1:0]        sr_adj;
    logic [SR_W-1:0]        sr_nxt;
    logic [BCD_CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]       bcd_q;
    logic                   last_iter;

    // Per-digit +3 correction ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[WIDTH + 4*g +: 4]),
            .dout (sr_adj[WIDTH + 4*g +: 4])
        );
    end

    assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];
    assign sr_nxt            = sr_adj << 1;
    assign last_iter         = (cnt == BCD_CNT_W'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CONVERT;
            CONVERT: if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CONVERT);
    assign out_valid = (state == DONE);

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr  <= {{BCD_W{1'b0}}, product_in};
                        cnt <= '0;
                    end
                end
                CONVERT: begin
                    sr  <= sr_nxt;
                    cnt <= cnt + 1'b1;
                    // Result captured on the same edge as the final shift.
                    if (last_iter) begin
                        bcd_q <= sr_nxt[SR_W-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = bcd_q;

`ifdef PRODUCT_BCD_SEG7_EN
    // Display patterns follow bcd_out by one cycle; leading zero hundreds
    // digit is blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_hund <= 7'b1111111;
            seg_tens <= 7'b1111111;
            seg_ones <= 7'b1111111;
        end else begin
            seg_hund <= (bcd_q[11:8] == 4'd0) ? 7'b1111111 : seg7_lut(bcd_q[11:8]);
            seg_tens <= seg7_lut(bcd_q[7:4]);
            seg_ones <= seg7_lut(bcd_q[3:0]);
        end
    end
`endif

endmodule
